// File: rtl/motor_encoder_reader_if.sv
// Bundle of encoder pins, control and decoded outputs for one motor channel.
// CNT_W must match the CNT_W of the attached motor_encoder_reader.
interface motor_encoder_reader_if #(
   parameter int unsigned CNT_W = 16
);
   logic             sa;
   logic             sb;
   logic             en;
   logic             clr;
   logic [CNT_W-1:0] pos;
   logic             dir;
   logic [CNT_W-1:0] speed;
   logic             speed_valid;
   logic             err;

   modport master (
      output sa, sb, en, clr,
      input  pos, dir, speed, speed_valid, err
   );

   modport slave (
      input  sa, sb, en, clr,
      output pos, dir, speed, speed_valid, err
   );
endinterface

// File: rtl/motor_encoder_reader.sv
// Quadrature encoder reader: sync + glitch filter per channel, step decoder,
// wrapping position, direction, sticky illegal-transition flag and windowed speed.
module motor_encoder_reader #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned FILT       = 4,
   parameter int unsigned WIN_CYCLES = 1000000
) (
   input logic                   clk,
   input logic                   rstn,
   motor_encoder_reader_if.slave bus
);

   localparam int unsigned FW = $clog2(FILT + 1);
   localparam int unsigned WW = $clog2(WIN_CYCLES);

   // Bit 1 is channel A, bit 0 is channel B throughout.
   logic [1:0]         s1_q, s2_q;
   logic [1:0]         filt_q, filt_d, prev_q;
   logic [1:0][FW-1:0] fcnt_q, fcnt_d;

   logic [CNT_W-1:0] pos_q, pos_d, acc_q, acc_d, speed_q, speed_d;
   logic [WW-1:0]    wcnt_q, wcnt_d;
   logic             dir_q, dir_d, err_q, err_d, sv_q, sv_d;
   logic             step_fwd, step_rev, step_bad, step_any;

   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] != filt_q[i]) begin
            if (fcnt_q[i] == FW'(FILT - 1)) filt_d[i] = s2_q[i];
            else                            fcnt_d[i] = fcnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      step_fwd = 1'b0;
      step_rev = 1'b0;
      case ({prev_q, filt_q})
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_fwd = 1'b1;
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_rev = 1'b1;
         default: ;
      endcase
      step_bad = ((prev_q ^ filt_q) == 2'b11);
      step_any = step_fwd | step_rev;
   end

   always_comb begin
      pos_d   = pos_q;
      dir_d   = dir_q;
      err_d   = err_q | step_bad;
      acc_d   = acc_q;
      wcnt_d  = wcnt_q;
      speed_d = speed_q;
      sv_d    = 1'b0;
      if (bus.clr) begin
         // clr wins over a coincident step or terminal count.
         pos_d  = '0;
         err_d  = 1'b0;
         acc_d  = '0;
         wcnt_d = '0;
      end else if (bus.en) begin
         if (step_fwd) begin
            pos_d = pos_q + 1'b1;
            dir_d = 1'b1;
         end else if (step_rev) begin
            pos_d = pos_q - 1'b1;
            dir_d = 1'b0;
         end
         if (wcnt_q == WW'(WIN_CYCLES - 1)) begin
            speed_d = acc_q;
            sv_d    = 1'b1;
            wcnt_d  = '0;
            acc_d   = step_any ? CNT_W'(1) : '0;
         end else begin
            wcnt_d = wcnt_q + 1'b1;
            if (step_any && acc_q != '1) acc_d = acc_q + 1'b1;
         end
      end else begin
         wcnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_q    <= 2'b00;
         s2_q    <= 2'b00;
         filt_q  <= 2'b00;
         fcnt_q  <= '0;
         prev_q  <= 2'b00;
         pos_q   <= '0;
         dir_q   <= 1'b1;
         err_q   <= 1'b0;
         acc_q   <= '0;
         wcnt_q  <= '0;
         speed_q <= '0;
         sv_q    <= 1'b0;
      end else begin
         s1_q    <= {bus.sa, bus.sb};
         s2_q    <= s1_q;
         filt_q  <= filt_d;
         fcnt_q  <= fcnt_d;
         prev_q  <= filt_q;
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
         acc_q   <= acc_d;
         wcnt_q  <= wcnt_d;
         speed_q <= speed_d;
         sv_q    <= sv_d;
      end
   end

   assign bus.pos         = pos_q;
   assign bus.dir         = dir_q;
   assign bus.err         = err_q;
   assign bus.speed       = speed_q;
   assign bus.speed_valid = sv_q;

endmodule

// File: tb/tb_motor_encoder_reader.sv
// Scoreboard bench for motor_encoder_reader: expected steps/speeds are queued
// as pins are driven and popped when the DUT output changes.
module tb_motor_encoder_reader;

   localparam int unsigned CW   = 16;
   localparam int unsigned FILT = 4;
   localparam int unsigned WIN  = 100;

   typedef struct packed {
      logic [CW-1:0] pos;
      logic          dir;
   } step_exp_t;

   typedef struct packed {
      logic [CW-1:0] speed;
      int unsigned   cyc;
   } spd_exp_t;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   motor_encoder_reader_if #(.CNT_W(CW)) bus ();

   motor_encoder_reader #(
      .CNT_W      (CW),
      .FILT       (FILT),
      .WIN_CYCLES (WIN)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int n_total = 0;
   int n_bad   = 0;

   step_exp_t step_q[$];
   spd_exp_t  spd_q[$];
   logic [1:0]    seq [4];
   logic [1:0]    idx;
   logic [CW-1:0] m_pos;
   logic          m_dir;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   // One legal step: queue expectation, drive, and check value and latency.
   task automatic do_step(input bit fwd, input int hold);
      logic [CW-1:0] old;
      int            lat;
      step_exp_t     e;
      idx   = fwd ? idx + 2'd1 : idx - 2'd1;
      m_pos = fwd ? m_pos + 1'b1 : m_pos - 1'b1;
      m_dir = fwd;
      step_q.push_back('{pos: m_pos, dir: m_dir});
      @(negedge clk);
      old = bus.pos;
      {bus.sa, bus.sb} = seq[idx];
      lat = 0;
      for (int c = 1; c <= hold; c++) begin
         @(posedge clk);
         #1;
         if (lat == 0 && bus.pos !== old) begin
            lat = c;
            e = step_q.pop_front();
            check("step_pos", 32'(bus.pos), 32'(e.pos));
            check("step_dir", 32'(bus.dir), 32'(e.dir));
            // c counts the capture edge itself as 1.
            check("step_latency", 32'(c - 1), 32'(FILT + 2));
         end
      end
      if (lat == 0) begin
         check("step_timeout", 32'(0), 32'(1));
         e = step_q.pop_front();
      end
   endtask

   // Wait for n queued position changes already set in motion.
   task automatic wait_changes(input int n, input int budget);
      logic [CW-1:0] old;
      int            got;
      step_exp_t     e;
      old = bus.pos;
      got = 0;
      for (int c = 1; c <= budget && got < n; c++) begin
         @(posedge clk);
         #1;
         if (bus.pos !== old) begin
            e = step_q.pop_front();
            check("chg_pos", 32'(bus.pos), 32'(e.pos));
            check("chg_dir", 32'(bus.dir), 32'(e.dir));
            old = bus.pos;
            got++;
         end
      end
      if (got < n) begin
         check("chg_timeout", 32'(got), 32'(n));
         step_q.delete();
      end
   endtask

   task automatic idle(input int n, output int sv_cnt);
      sv_cnt = 0;
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1;
         if (bus.speed_valid) sv_cnt++;
      end
   endtask

   task automatic watch_windows();
      int       pulses;
      spd_exp_t e;
      pulses = 0;
      for (int c = 1; c <= 260 && pulses < 2; c++) begin
         @(posedge clk);
         #1;
         if (bus.speed_valid) begin
            e = spd_q.pop_front();
            check("win_speed", 32'(bus.speed), 32'(e.speed));
            check("win_cycle", 32'(c), e.cyc);
            pulses++;
         end
      end
      if (pulses < 2) check("win_pulses", 32'(pulses), 32'(2));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, total=%0d", n_total);
      $fatal(1);
   end

   initial begin
      int       sv_cnt, sv_sum;
      bit       seen_ffff;
      spd_exp_t se;
      bit       got_sv;

      seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
      idx = 2'd0; m_pos = '0; m_dir = 1'b1;
      rstn = 1'b0;
      bus.sa = 1'b0; bus.sb = 1'b0; bus.en = 1'b0; bus.clr = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_pos", 32'(bus.pos), 32'(0));
      check("rst_dir", 32'(bus.dir), 32'(1));
      check("rst_speed", 32'(bus.speed), 32'(0));
      check("rst_sv", 32'(bus.speed_valid), 32'(0));
      check("rst_err", 32'(bus.err), 32'(0));

      @(negedge clk);
      rstn = 1'b1;
      bus.en = 1'b1;

      for (int i = 0; i < 8; i++) do_step(1'b1, 20);
      check("fwd8_pos", 32'(bus.pos), 32'(8));
      check("fwd8_dir", 32'(bus.dir), 32'(1));
      check("fwd8_err", 32'(bus.err), 32'(0));

      seen_ffff = 1'b0;
      for (int i = 0; i < 10; i++) begin
         do_step(1'b0, 20);
         if (bus.pos === 16'hFFFF) seen_ffff = 1'b1;
      end
      check("rev10_pos", 32'(bus.pos), 32'(16'hFFFE));
      check("rev10_dir", 32'(bus.dir), 32'(0));
      check("wrap_ffff_seen", 32'(seen_ffff), 32'(1));

      // Pins are 11; a short sa pulse must vanish.
      @(negedge clk);
      bus.sa = ~bus.sa;
      repeat (FILT - 1) @(negedge clk);
      bus.sa = ~bus.sa;
      idle(20, sv_cnt);
      check("glitch_short_pos", 32'(bus.pos), 32'(m_pos));

      // A FILT-long pulse passes: forward to 01, then back to 11.
      step_q.push_back('{pos: m_pos + 1'b1, dir: 1'b1});
      step_q.push_back('{pos: m_pos, dir: 1'b0});
      m_dir = 1'b0;
      @(negedge clk);
      bus.sa = ~bus.sa;
      repeat (FILT) @(negedge clk);
      bus.sa = ~bus.sa;
      wait_changes(2, 40);

      do_step(1'b1, 20);
      do_step(1'b1, 20);
      @(negedge clk);
      {bus.sa, bus.sb} = 2'b11;
      idx = 2'd2;
      idle(20, sv_cnt);
      check("jump_err", 32'(bus.err), 32'(1));
      check("jump_pos", 32'(bus.pos), 32'(m_pos));

      @(negedge clk);
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      m_pos = '0;
      check("clr_err", 32'(bus.err), 32'(0));
      check("clr_pos", 32'(bus.pos), 32'(0));

      // Fresh window: en low with clr, then 5 steps inside the first window.
      @(negedge clk);
      bus.en = 1'b0;
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      bus.en = 1'b1;
      spd_q.push_back('{speed: CW'(5), cyc: WIN});
      spd_q.push_back('{speed: CW'(0), cyc: 2 * WIN});
      fork
         watch_windows();
         for (int i = 0; i < 5; i++) do_step(1'b1, 15);
      join

      // Pins move while disabled; nothing may count or fire.
      @(negedge clk);
      bus.en = 1'b0;
      sv_sum = 0;
      for (int i = 0; i < 3; i++) begin
         idx = idx + 2'd1;
         @(negedge clk);
         {bus.sa, bus.sb} = seq[idx];
         idle(20, sv_cnt);
         sv_sum += sv_cnt;
      end
      check("dis_pos", 32'(bus.pos), 32'(m_pos));
      check("dis_sv", 32'(sv_sum), 32'(0));
      @(negedge clk);
      bus.en = 1'b1;
      idle(30, sv_cnt);
      check("reen_pos", 32'(bus.pos), 32'(m_pos));
      check("reen_dir", 32'(bus.dir), 32'(1));
      check("reen_err", 32'(bus.err), 32'(0));

      spd_q.push_back('{speed: CW'(2), cyc: 0});
      do_step(1'b0, 20);
      do_step(1'b0, 20);
      got_sv = 1'b0;
      for (int c = 0; c < 150 && !got_sv; c++) begin
         @(posedge clk);
         #1;
         if (bus.speed_valid) begin
            got_sv = 1'b1;
            se = spd_q.pop_front();
            check("reen_speed", 32'(bus.speed), 32'(se.speed));
         end
      end
      if (!got_sv) check("reen_speed_timeout", 32'(0), 32'(1));

      do_step(1'b0, 20);
      idle(10, sv_cnt);
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check("arst_pos", 32'(bus.pos), 32'(0));
      check("arst_dir", 32'(bus.dir), 32'(1));
      check("arst_speed", 32'(bus.speed), 32'(0));
      check("arst_sv", 32'(bus.speed_valid), 32'(0));
      check("arst_err", 32'(bus.err), 32'(0));

      // Pins sit at 01 through reset: acquired as one reverse step from 00.
      @(negedge clk);
      step_q.push_back('{pos: 16'hFFFF, dir: 1'b0});
      rstn = 1'b1;
      wait_changes(1, 30);
      check("post_rst_err", 32'(bus.err), 32'(0));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/motor_encoder_reader.md
Name: motor_encoder_reader

Overview:
Receive-side counterpart to the H-bridge motor drive. Decodes the quadrature hall-sensor feedback (SA/SB) returned from the motor/H-bridge Pmod on the same JB connector. Produces a wrapping position count, direction, and a per-window edge-rate (speed) for closed-loop speed control and odometry. One instance per motor.

Parameters:
CNT_W, 16, width of pos and speed outputs
FILT, 4, consecutive identical synchronised samples required to accept a new pin level (min 1)
WIN_CYCLES, 1000000, speed measurement window in clk cycles (10 ms at 100 MHz, min 2)

Ports:
clk  input  1  system clock
rstn  input  1  reset, asynchronous assert, active-low
sa  input  1  encoder channel A from motor connector, asynchronous
sb  input  1  encoder channel B from motor connector, asynchronous
en  input  1  1 = count and measure; 0 = hold pos/speed
clr  input  1  synchronous clear of pos, err, and the speed accumulator
pos  output  CNT_W  position count, two's complement, wraps modulo 2^CNT_W
dir  output  1  direction of last valid step: 1 = forward, 0 = reverse
speed  output  CNT_W  valid steps counted in the last completed window, saturating
speed_valid  output  1  one-cycle pulse when speed updates
err  output  1  sticky flag: illegal quadrature transition seen

Behaviour:
- Reset (rstn=0, async): pos=0, dir=1, speed=0, speed_valid=0, err=0. Sync, filter and decoder state load 00. Window counter=0.
- Synchroniser: 2 flip-flops per channel. No logic on the first stage.
- Glitch filter, per channel, independent:
  - The counter increments while the synced value differs from the filtered value.
  - The counter resets to 0 whenever the synced value equals the filtered value.
  - The filtered value takes the new level on the FILT-th consecutive differing sample.
  - Pulses shorter than FILT cycles are discarded.
- Decoder: compares the registered previous filtered pair {A,B} with the current pair.
  - Forward sequence: 00→10→11→01→00 (A leads B). Each step: pos+1, dir=1.
  - Reverse sequence: 00→01→11→10→00. Each step: pos−1, dir=0.
  - No change: nothing happens.
  - Both bits change (00↔11, 10↔01): err=1, pos and dir unchanged, previous pair updated to the current pair.
- Latency: pos/dir change FILT+2 clk cycles after the rising edge that first captures a new stable pin level into sync stage 1.
- pos arithmetic is modulo 2^CNT_W: 0−1 = all ones; max+1 = 0.
- Speed window:
  - The window counter runs 0..WIN_CYCLES−1 while en=1.
  - The accumulator counts valid steps in either direction and saturates at 2^CNT_W−1.
  - At terminal count: speed takes the accumulator value, speed_valid=1 for exactly one cycle, and the counter returns to 0.
  - The accumulator restarts at 0. A step on the terminal cycle is counted as 1 in the new window.
  - An illegal transition does not increment the accumulator.
- en=0:
  - The filter and decoder keep tracking the pins, so re-enabling produces no spurious step.
  - pos, dir and the accumulator hold. The window counter holds at 0. No speed_valid. speed holds its last value.
- clr=1:
  - pos=0, err=0, accumulator=0, window counter=0. dir and speed hold.
  - clr has priority over a simultaneous step or terminal count: that step is dropped and no speed_valid is produced.
- Reset mid-operation: all state returns to reset values immediately.
  - If the pins are not 00 after reset, the filter acquires them after FILT+1 cycles.
  - The move from 00 to the first acquired pair is decoded normally: a single-bit change counts one step; 11 sets err.

Test Plan:
- Reset, en=1, drive 8 forward steps (00,10,11,01,...) each held 20 cycles → pos=8, dir=1, err=0. Each update occurs exactly FILT+2 cycles after the step's first capture edge.
- From pos=8, drive 10 reverse steps → pos=0xFFFE (−2), dir=0. Continue until pos passes through 0 → 0xFFFF wrap is observed.
- Glitch on sa of FILT−1 cycles (3 cycles at FILT=4) → pos unchanged. Repeat with 4 cycles → pos+1.
- Jump pins 00→11 in one sample → err=1, pos unchanged. Assert clr for 1 cycle → err=0, pos=0.
- WIN_CYCLES=100, 5 forward steps in the first window → speed_valid pulses at cycle 100 with speed=5. Next window with no steps → speed=0.
- Drive steps, set en=0, move pins 3 steps, set en=1 → pos unchanged and no step on re-enable. Then assert rstn=0 mid-window → all outputs 0 and dir=1 asynchronously, before the next clk edge.
